// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit owning the architectural HI/LO registers.
// Latency: mult/multu MULT_CYCLES, div/divu DIV_CYCLES busy cycles; mthi/mtlo write on the next edge.
// Backpressure: none internal; busy (with start) is used upstream to stall MDU instructions, so starts while busy are dropped.
//
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   start        E-stage instruction is mult/multu/div/divu this cycle
//   md_op        0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo
//   a, b         forwarded rs / rt operands
//   busy         an operation is in progress
//   hi, lo       HI / LO registers (registered outputs only)
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q;
  logic [31:0]   a_q, b_q;
  logic          latch_en;
  logic          done;

  // Arithmetic datapath, evaluated on the latched operands only.
  logic signed [63:0] a_sx, b_sx, prod_s;
  logic [63:0]        prod_u;
  logic               is_signed_div;
  logic [31:0]        mag_a, mag_b, uq, ur;
  logic [31:0]        res_hi, res_lo;
  logic               res_we;

  always_comb begin
    a_sx   = $signed({{32{a_q[31]}}, a_q});
    b_sx   = $signed({{32{b_q[31]}}, b_q});
    prod_s = a_sx * b_sx;
    prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Signed divide goes through magnitudes so 0x80000000 / -1 wraps to
    // 0x80000000 with zero remainder rather than relying on signed overflow.
    is_signed_div = (op_q == OP_DIV);
    mag_a = (is_signed_div && a_q[31]) ? -a_q : a_q;
    mag_b = (is_signed_div && b_q[31]) ? -b_q : b_q;
    uq    = (mag_b != 32'd0) ? (mag_a / mag_b) : 32'd0;
    ur    = (mag_b != 32'd0) ? (mag_a % mag_b) : 32'd0;

    res_hi = hi;
    res_lo = lo;
    res_we = 1'b0;
    case (op_q)
      OP_MULT:  begin res_we = 1'b1; {res_hi, res_lo} = prod_s; end
      OP_MULTU: begin res_we = 1'b1; {res_hi, res_lo} = prod_u; end
      OP_DIV: begin
        res_we = (b_q != 32'd0);
        res_lo = (a_q[31] ^ b_q[31]) ? -uq : uq;
        res_hi = a_q[31] ? -ur : ur;
      end
      OP_DIVU: begin
        res_we = (b_q != 32'd0);
        res_lo = uq;
        res_hi = ur;
      end
      default: res_we = 1'b0;
    endcase
  end

  // Next-state: start is honoured only while idle; the final busy edge
  // (counter 1 -> 0) commits the result and returns to idle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_en = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && (md_op >= OP_MULT) && (md_op <= OP_DIVU)) begin
          latch_en = 1'b1;
          cnt_d    = (md_op == OP_DIV || md_op == OP_DIVU) ? DIV_N : MULT_N;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_en) begin
        op_q <= md_op;
        a_q  <= a;
        b_q  <= b;
      end
      if (done && res_we) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if (state_q == S_IDLE && !start) begin
        if (md_op == OP_MTHI) hi <= a;
        if (md_op == OP_MTLO) lo <= a;
      end
    end
  end

  assign busy = (state_q == S_BUSY);

endmodule
